// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: byte/half/word loads
// and stores with alignment and range checking, one request per LATENCY+1 cycles.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT       state;
    logic [3:0]  cnt;
    logic        pendErr;
    logic [31:0] pendData;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       rdWord;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic              sizeErr;
    logic              addrOob;
    logic              accessErr;
    logic [3:0]        byteEn;
    logic [31:0]       wrData;
    logic [31:0]       loadVal;
    logic [31:0]       respData;

    assign accept   = req_valid && req_ready;
    assign wordIdx  = req_addr[ADDR_W+1:2];
    assign rdWord   = mem[wordIdx];
    assign laneByte = rdWord[{req_addr[1:0], 3'b000} +: 8];
    assign laneHalf = req_addr[1] ? rdWord[31:16] : rdWord[15:0];
    assign addrOob  = {1'b0, req_addr} >= ADDR_LIMIT;

    // Decode size into lane enables, replicated store data and extended load data
    always_comb begin
        sizeErr = 1'b0;
        byteEn  = 4'b0000;
        wrData  = 32'd0;
        loadVal = 32'd0;
        case (req_size)
            2'b00: begin
                sizeErr = req_addr[1:0] != 2'b00;
                byteEn  = 4'b1111;
                wrData  = req_wdata;
                loadVal = rdWord;
            end
            2'b01: begin
                sizeErr = req_addr[0];
                byteEn  = req_addr[1] ? 4'b1100 : 4'b0011;
                wrData  = {2{req_wdata[15:0]}};
                loadVal = {{16{~req_unsigned & laneHalf[15]}}, laneHalf};
            end
            2'b10: begin
                byteEn  = 4'b0001 << req_addr[1:0];
                wrData  = {4{req_wdata[7:0]}};
                loadVal = {{24{~req_unsigned & laneByte[7]}}, laneByte};
            end
            default: sizeErr = 1'b1;
        endcase
    end

    assign accessErr = sizeErr || addrOob;
    assign respData  = (accessErr || req_we) ? 32'd0 : loadVal;

    // Storage array has no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (accept && req_we && !accessErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    // Request/response sequencing; all outputs are registered alongside state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            pendErr    <= 1'b0;
            pendData   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        pendErr   <= accessErr;
                        pendData  <= respData;
                        if (LATENCY <= 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= accessErr;
                            resp_rdata <= respData;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state      <= RESP;
                        cnt        <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_err   <= pendErr;
                        resp_rdata <= pendData;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder: directed accesses with hand-computed
// results, plus back-to-back and reset-in-WAIT sequences.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int nChecks = 0;
    int nFails  = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] expData;
        logic        expErr;
        string       name;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vecT mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input logic [31:0] expData,
                               input logic expErr, input string name);
        vecT v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.expData = expData; v.expErr = expErr; v.name = name;
        return v;
    endfunction

    // One access: present on a negedge, accepted on the next posedge, then walk the
    // LAT+1 cycles until ready returns, checking the exact response cycle.
    task automatic runAccess(input vecT v);
        @(negedge clk);
        req_we       = v.we;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_valid    = 1'b1;
        check({v.name, " ready_before"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check($sformatf("%s valid_c%0d", v.name, k), 32'(resp_valid), 32'(k == int'(LAT)));
            check($sformatf("%s ready_c%0d", v.name, k), 32'(req_ready), 32'(k == int'(LAT) + 1));
            check($sformatf("%s err_c%0d", v.name, k), 32'(resp_err),
                  (k == int'(LAT)) ? 32'(v.expErr) : 32'd0);
            check($sformatf("%s rdata_c%0d", v.name, k), resp_rdata,
                  (k == int'(LAT)) ? v.expData : 32'd0);
        end
    endtask

    initial begin
        int  acc[3];
        int  nAcc;
        int  nResp;
        logic prevRv;
        logic drop;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;

        #12;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset valid", 32'(resp_valid), 32'd0);
        check("reset err", 32'(resp_err), 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //            we    addr          wdata         size  uns   expData       err
        vecs.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_0000, 1'b0, "st_w_10"));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0, "ld_w_10"));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b0, "clr_w_20"));
        vecs.push_back(mk(1'b1, 32'h0000_0021, 32'h1234_5680, 2'b10, 1'b0, 32'h0000_0000, 1'b0, "st_b_21"));
        vecs.push_back(mk(1'b0, 32'h0000_0021, 32'h0,         2'b10, 1'b0, 32'hFFFF_FF80, 1'b0, "ld_bs_21"));
        vecs.push_back(mk(1'b0, 32'h0000_0021, 32'h0,         2'b10, 1'b1, 32'h0000_0080, 1'b0, "ld_bu_21"));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         2'b00, 1'b0, 32'h0000_8000, 1'b0, "ld_w_20"));
        vecs.push_back(mk(1'b1, 32'h0000_0004, 32'h1122_3344, 2'b00, 1'b0, 32'h0000_0000, 1'b0, "st_w_04"));
        vecs.push_back(mk(1'b0, 32'h0000_0003, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1, "ld_h_03_mis"));
        vecs.push_back(mk(1'b1, 32'h0000_0006, 32'h1234_5678, 2'b00, 1'b0, 32'h0000_0000, 1'b1, "st_w_06_mis"));
        vecs.push_back(mk(1'b0, 32'h0000_0004, 32'h0,         2'b00, 1'b0, 32'h1122_3344, 1'b0, "ld_w_04"));
        vecs.push_back(mk(1'b0, 32'h0000_1000, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b1, "ld_w_oob"));
        vecs.push_back(mk(1'b1, 32'h0000_1000, 32'hFF,        2'b10, 1'b0, 32'h0000_0000, 1'b1, "st_b_oob"));
        vecs.push_back(mk(1'b1, 32'h0000_0FFE, 32'hAAAA_8001, 2'b01, 1'b0, 32'h0000_0000, 1'b0, "st_h_ffe"));
        vecs.push_back(mk(1'b0, 32'h0000_0FFE, 32'h0,         2'b01, 1'b0, 32'hFFFF_8001, 1'b0, "ld_hs_ffe"));
        vecs.push_back(mk(1'b0, 32'h0000_0FFE, 32'h0,         2'b01, 1'b1, 32'h0000_8001, 1'b0, "ld_hu_ffe"));
        vecs.push_back(mk(1'b0, 32'h0000_0FFF, 32'h0,         2'b10, 1'b0, 32'hFFFF_FF80, 1'b0, "ld_bs_fff"));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1, "ld_sz11"));
        vecs.push_back(mk(1'b1, 32'h0000_0010, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1, "st_sz11"));
        vecs.push_back(mk(1'b1, 32'h0000_0011, 32'h5555,      2'b01, 1'b0, 32'h0000_0000, 1'b1, "st_h_11_mis"));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0, "ld_w_10_again"));
        vecs.push_back(mk(1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b0, 32'hFFFF_DEAD, 1'b0, "ld_hs_12"));
        vecs.push_back(mk(1'b0, 32'h0000_0013, 32'h0,         2'b10, 1'b1, 32'h0000_00DE, 1'b0, "ld_bu_13"));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hFFFF_FFEF, 1'b0, "ld_bs_10"));

        foreach (vecs[i]) runAccess(vecs[i]);

        // Three loads with req_valid held high: accepts must land every LAT+1 cycles
        nAcc   = 0;
        nResp  = 0;
        prevRv = 1'b0;
        drop   = 1'b0;
        @(negedge clk);
        req_we       = 1'b0;
        req_addr     = 32'h0000_0010;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_valid    = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (req_valid && req_ready && nAcc < 3) begin
                acc[nAcc] = cyc;
                nAcc++;
                if (nAcc == 3) drop = 1'b1;
            end
            if (resp_valid) begin
                nResp++;
                check("b2b no_consecutive_valid", 32'(prevRv), 32'd0);
                check("b2b rdata", resp_rdata, 32'hDEAD_BEEF);
            end
            prevRv = resp_valid;
            @(negedge clk);
            if (drop) req_valid = 1'b0;
        end
        check("b2b accept_count", 32'(nAcc), 32'd3);
        check("b2b resp_count", 32'(nResp), 32'd3);
        if (nAcc == 3) begin
            check("b2b spacing_1", 32'(acc[1] - acc[0]), 32'(LAT + 1));
            check("b2b spacing_2", 32'(acc[2] - acc[1]), 32'(LAT + 1));
        end

        // Reset while in WAIT: response is dropped, the store stays committed
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h0000_00A5;
        req_size  = 2'b10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_wait ready", 32'(req_ready), 32'd1);
        check("rst_wait valid", 32'(resp_valid), 32'd0);
        check("rst_wait err", 32'(resp_err), 32'd0);
        check("rst_wait rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_wait no_resp_%0d", k), 32'(resp_valid), 32'd0);
        end
        runAccess(mk(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFA5, 1'b0, "ld_bs_40_after_rst"));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
